// File: rtl/vj_weak_eval_seq.sv
// Sequential Viola-Jones stage evaluator: walks NUM_WEAK weak classifiers from a feature ROM,
// sums rectangle features from a 20x20 integral image and votes alphas into a stage score.
module vj_weak_eval_seq #(
  parameter int unsigned NUM_WEAK = 16,
  parameter int unsigned COORD_W  = 6,
  parameter int unsigned THRESH_W = 32,
  parameter int unsigned ALPHA_W  = 16,
  parameter int unsigned II_W     = 20,
  parameter int unsigned SCORE_W  = 24,
  localparam int unsigned IDX_W   = (NUM_WEAK > 1) ? $clog2(NUM_WEAK) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic signed [SCORE_W-1:0]  stage_thresh,
  output logic                       busy,
  output logic                       done,
  output logic                       face,
  output logic signed [SCORE_W-1:0]  score,
  output logic                       err,
  output logic [IDX_W-1:0]           rom_idx,
  input  logic [2:0]                 rect_count,
  input  logic [COORD_W-1:0]         rx0, rx1, rx2, rx3,
  input  logic [COORD_W-1:0]         ry0, ry1, ry2, ry3,
  input  logic [COORD_W-1:0]         rw0, rw1, rw2, rw3,
  input  logic [COORD_W-1:0]         rh0, rh1, rh2, rh3,
  input  logic signed [3:0]          wt0, wt1, wt2, wt3,
  input  logic signed [THRESH_W-1:0] threshold,
  input  logic signed [ALPHA_W-1:0]  alpha,
  input  logic                       polarity,
  output logic                       ii_rd_en,
  output logic [8:0]                 ii_addr,
  input  logic [II_W-1:0]            ii_rd_data
);

  localparam int unsigned CMP_W = (THRESH_W > 32) ? THRESH_W : 32;

  typedef enum logic [2:0] {StIdle, StLoad, StRead, StDrain, StVote, StDone} state_t;

  state_t                      r_state, w_state_d;
  logic [IDX_W-1:0]            r_idx;
  logic signed [SCORE_W-1:0]   r_score;
  logic                        r_face, r_done, r_err;
  logic [2:0]                  r_n;
  logic [COORD_W-1:0]          r_rx [4];
  logic [COORD_W-1:0]          r_ry [4];
  logic [COORD_W-1:0]          r_rw [4];
  logic [COORD_W-1:0]          r_rh [4];
  logic signed [3:0]           r_wt [4];
  logic signed [THRESH_W-1:0]  r_thr;
  logic signed [ALPHA_W-1:0]   r_alpha;
  logic                        r_pol;
  logic signed [31:0]          r_f;
  logic [3:0]                  r_cnt;
  logic                        r_pend_vld, r_pend_neg;
  logic signed [3:0]           r_pend_wt;

  logic [2:0]                  w_n_in;
  logic [1:0]                  w_k, w_c;
  logic [COORD_W:0]            w_xe, w_ye, w_cx, w_cy;
  logic                        w_oor, w_last_rd, w_last_idx, w_pass;
  logic signed [31:0]          w_data_s, w_wt_s, w_term;
  logic signed [CMP_W-1:0]     w_f_ext, w_thr_ext;
  logic signed [SCORE_W-1:0]   w_alpha_ext;

  assign w_n_in     = (rect_count > 3'd4) ? 3'd4 : rect_count;
  assign w_k        = r_cnt[3:2];
  assign w_c        = r_cnt[1:0];
  assign w_xe       = {1'b0, r_rx[w_k]} + {1'b0, r_rw[w_k]};
  assign w_ye       = {1'b0, r_ry[w_k]} + {1'b0, r_rh[w_k]};
  assign w_oor      = (w_xe > (COORD_W+1)'(19)) || (w_ye > (COORD_W+1)'(19));
  // Corner order D, B, C, A: bit1 selects x vs x+w, bit0 selects y vs y+h.
  assign w_cx       = w_c[1] ? {1'b0, r_rx[w_k]} : w_xe;
  assign w_cy       = w_c[0] ? {1'b0, r_ry[w_k]} : w_ye;
  assign w_last_rd  = (w_k == 2'(r_n - 3'd1)) && (w_c == 2'd3);
  assign w_last_idx = (r_idx == IDX_W'(NUM_WEAK - 1));

  assign w_data_s    = 32'(ii_rd_data);
  assign w_wt_s      = 32'(r_pend_wt);
  assign w_term      = w_data_s * w_wt_s;
  assign w_f_ext     = CMP_W'(r_f);
  assign w_thr_ext   = CMP_W'(r_thr);
  assign w_pass      = r_pol ? (w_f_ext < w_thr_ext) : (w_f_ext >= w_thr_ext);
  assign w_alpha_ext = SCORE_W'(r_alpha);

  assign ii_rd_en = (r_state == StRead) && !w_oor;
  assign ii_addr  = ii_rd_en ? (9'(w_cy) * 9'd20 + 9'(w_cx)) : 9'd0;
  assign busy     = (r_state != StIdle) && (r_state != StDone);
  assign done     = r_done;
  assign face     = r_face;
  assign score    = r_score;
  assign err      = r_err;
  assign rom_idx  = r_idx;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (start) w_state_d = StLoad;
      StLoad:  w_state_d = (w_n_in == 3'd0) ? StDrain : StRead;
      StRead:  if (w_last_rd) w_state_d = StDrain;
      StDrain: w_state_d = StVote;
      StVote:  w_state_d = w_last_idx ? StDone : StLoad;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_idx      <= '0;
      r_score    <= '0;
      r_face     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_n        <= '0;
      for (int i = 0; i < 4; i++) begin
        r_rx[i] <= '0;
        r_ry[i] <= '0;
        r_rw[i] <= '0;
        r_rh[i] <= '0;
        r_wt[i] <= '0;
      end
      r_thr      <= '0;
      r_alpha    <= '0;
      r_pol      <= 1'b0;
      r_f        <= '0;
      r_cnt      <= '0;
      r_pend_vld <= 1'b0;
      r_pend_neg <= 1'b0;
      r_pend_wt  <= '0;
    end else begin
      r_state    <= w_state_d;
      r_done     <= (r_state == StDone);
      r_pend_vld <= ii_rd_en;
      r_pend_neg <= w_c[0] ^ w_c[1];
      r_pend_wt  <= r_wt[w_k];
      if (r_pend_vld) r_f <= r_pend_neg ? (r_f - w_term) : (r_f + w_term);
      unique case (r_state)
        StIdle: begin
          r_idx <= '0;
          if (start) begin
            r_score <= '0;
            r_err   <= 1'b0;
            r_face  <= 1'b0;
          end
        end
        StLoad: begin
          r_n     <= w_n_in;
          r_rx    <= '{rx0, rx1, rx2, rx3};
          r_ry    <= '{ry0, ry1, ry2, ry3};
          r_rw    <= '{rw0, rw1, rw2, rw3};
          r_rh    <= '{rh0, rh1, rh2, rh3};
          r_wt    <= '{wt0, wt1, wt2, wt3};
          r_thr   <= threshold;
          r_alpha <= alpha;
          r_pol   <= polarity;
          r_f     <= '0;
          r_cnt   <= '0;
        end
        StRead: begin
          r_cnt <= r_cnt + 4'd1;
          if (w_oor) r_err <= 1'b1;
        end
        StVote: begin
          if (w_pass) r_score <= r_score + w_alpha_ext;
          if (!w_last_idx) r_idx <= r_idx + IDX_W'(1);
        end
        StDone: begin
          r_face <= (r_score >= stage_thresh);
          r_idx  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vj_weak_eval_seq.sv
// Directed bench for vj_weak_eval_seq: two-weak ROM, procedural integral-image model,
// latency, address trace, start filtering, mid-run reset and out-of-range rectangle.
module tb_vj_weak_eval_seq;

  logic               clk, rst_n, start;
  logic signed [23:0] stage_thresh;
  logic               busy, done, face, err, ii_rd_en;
  logic signed [23:0] score;
  logic [0:0]         rom_idx;
  logic [2:0]         rect_count;
  logic [5:0]         rx0, rx1, rx2, rx3, ry0, ry1, ry2, ry3;
  logic [5:0]         rw0, rw1, rw2, rw3, rh0, rh1, rh2, rh3;
  logic signed [3:0]  wt0, wt1, wt2, wt3;
  logic signed [31:0] threshold;
  logic signed [15:0] alpha;
  logic               polarity;
  logic [8:0]         ii_addr;
  logic [19:0]        ii_rd_data;

  int checks = 0;
  int errors = 0;
  int pix = 0;
  bit w1_alt = 1'b0;
  int addr_log[$];

  vj_weak_eval_seq #(.NUM_WEAK(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stage_thresh(stage_thresh),
    .busy(busy), .done(done), .face(face), .score(score), .err(err), .rom_idx(rom_idx),
    .rect_count(rect_count),
    .rx0(rx0), .rx1(rx1), .rx2(rx2), .rx3(rx3),
    .ry0(ry0), .ry1(ry1), .ry2(ry2), .ry3(ry3),
    .rw0(rw0), .rw1(rw1), .rw2(rw2), .rw3(rw3),
    .rh0(rh0), .rh1(rh1), .rh2(rh2), .rh3(rh3),
    .wt0(wt0), .wt1(wt1), .wt2(wt2), .wt3(wt3),
    .threshold(threshold), .alpha(alpha), .polarity(polarity),
    .ii_rd_en(ii_rd_en), .ii_addr(ii_addr), .ii_rd_data(ii_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    {rx0, rx1, rx2, rx3, ry0, ry1, ry2, ry3} = '0;
    {rw0, rw1, rw2, rw3, rh0, rh1, rh2, rh3} = '0;
    {wt0, wt1, wt2, wt3} = '0;
    if (rom_idx == 1'b0) begin
      rect_count = 3'd2;
      rx0 = 6'd1; ry0 = 6'd3; rw0 = 6'd1; rh0 = 6'd3; wt0 = 4'sd1;
      rx1 = 6'd1; ry1 = 6'd6; rw1 = 6'd1; rh1 = 6'd3; wt1 = -4'sd1;
      threshold = -32'sd61; alpha = 16'sd208; polarity = 1'b0;
    end else begin
      rect_count = 3'd1;
      if (w1_alt) begin
        rx0 = 6'd18; ry0 = 6'd0; rw0 = 6'd2; rh0 = 6'd1; wt0 = 4'sd1;
      end else begin
        rx0 = 6'd0; ry0 = 6'd0; rw0 = 6'd2; rh0 = 6'd2; wt0 = 4'sd1;
      end
      threshold = 32'sd100; alpha = 16'sd50; polarity = 1'b1;
    end
  end

  // Uniform image: II(y,x) = pix*x*y with the zero row/column at index 0.
  always @(posedge clk) begin
    if (ii_rd_en) begin
      ii_rd_data <= 20'(pix * (int'(ii_addr) % 20) * (int'(ii_addr) / 20));
      addr_log.push_back(int'(ii_addr));
    end
  end

  task automatic check_eq(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Starts a window and waits for done; optionally pulses start again mid-run.
  task automatic run(input bit mid, output int lat);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 60 && lat < 0; c++) begin
      if (mid && c == 4) start = 1'b1;
      if (mid && c == 5) start = 1'b0;
      @(posedge clk); #1;
      if (done) lat = c;
    end
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      if (done) n++;
    end
  endtask

  int lat, nd;
  logic signed [23:0] first_score;

  initial begin
    rst_n = 1'b1; start = 1'b0; stage_thresh = 24'sd258; ii_rd_data = '0;
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_face", face, 0);
    check_eq("rst_score", score, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_idx", rom_idx, 0);
    check_eq("rst_rden", ii_rd_en, 0);
    check_eq("rst_addr", ii_addr, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // All-zero image
    pix = 0; addr_log.delete();
    run(1'b0, lat);
    check_eq("zero_lat", lat, 19);
    check_eq("zero_score", score, 258);
    check_eq("zero_face", face, 1);
    check_eq("zero_err", err, 0);
    check_eq("zero_nreads", addr_log.size(), 12);
    @(posedge clk); #1;
    check_eq("done_pulse_1cyc", done, 0);
    check_eq("idle_busy", busy, 0);

    stage_thresh = 24'sd259;
    run(1'b0, lat);
    check_eq("th259_lat", lat, 19);
    check_eq("th259_face", face, 0);
    check_eq("th259_score", score, 258);

    // Uniform 255 image
    stage_thresh = 24'sd258; pix = 255; addr_log.delete();
    run(1'b0, lat);
    check_eq("u255_score", score, 208);
    check_eq("u255_err", err, 0);
    check_eq("u255_face", face, 0);
    check_eq("u255_nreads", addr_log.size(), 12);
    if (addr_log.size() == 12) begin
      check_eq("w1_addr_d", addr_log[8], 42);
      check_eq("w1_addr_b", addr_log[9], 2);
      check_eq("w1_addr_c", addr_log[10], 40);
      check_eq("w1_addr_a", addr_log[11], 0);
      check_eq("w0_addr_d", addr_log[0], 122);
    end
    count_dones(5, nd);
    check_eq("score_hold", score, 208);

    // start during busy ignored, then back-to-back restart
    run(1'b1, lat);
    check_eq("mid_lat", lat, 19);
    first_score = score;
    count_dones(25, nd);
    check_eq("mid_extra_done", nd, 0);
    check_eq("mid_score", first_score, 208);
    run(1'b0, lat);
    @(posedge clk); #1;
    run(1'b0, lat);
    check_eq("b2b_lat", lat, 19);
    check_eq("b2b_score", score, first_score);

    // Reset during W0 READ
    pix = 0;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("pre_rst_rden", ii_rd_en, 1);
    check_eq("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_busy", busy, 0);
    check_eq("async_rden", ii_rd_en, 0);
    check_eq("async_addr", ii_addr, 0);
    check_eq("async_score", score, 0);
    check_eq("async_face_err", {face, err, done}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    count_dones(25, nd);
    check_eq("rst_no_done", nd, 0);
    run(1'b0, lat);
    check_eq("rerun_lat", lat, 19);
    check_eq("rerun_score", score, 258);
    check_eq("rerun_face", face, 1);

    // Out-of-range W1 rectangle
    pix = 255; w1_alt = 1'b1; addr_log.delete();
    run(1'b0, lat);
    check_eq("oor_lat", lat, 19);
    check_eq("oor_err", err, 1);
    check_eq("oor_score", score, 258);
    check_eq("oor_nreads", addr_log.size(), 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vj_weak_eval_seq.md
VJ_WEAK_EVAL_SEQ -- requirements
Module: vj_weak_eval_seq

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- NUM_WEAK, 16: weak classifiers per stage.
- COORD_W, 6: rectangle coordinate width.
- THRESH_W, 32: signed threshold width.
- ALPHA_W, 16: signed alpha width.
- II_W, 20: unsigned integral-image word width.
- SCORE_W, 24: signed stage score width.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1: single clock, all state on rising edge.
- rst_n, in, 1: reset, asynchronous, active-low.
- start, in, 1: begin evaluating one 19x19 window.
- stage_thresh, in, SCORE_W signed: face decision threshold.
- busy, out, 1: evaluation in progress.
- done, out, 1: one-cycle completion pulse.
- face, out, 1: decision, valid from done until next start.
- score, out, SCORE_W signed: final alpha sum.
- err, out, 1: out-of-range rectangle seen in this window.
- rom_idx, out, clog2(NUM_WEAK): feature ROM index.
- rect_count, in, 3: rectangles used.
- rx0..rx3, ry0..ry3, rw0..rw3, rh0..rh3, in, COORD_W each: rectangle geometry.
- wt0..wt3, in, 4 signed: rectangle weights.
- threshold, in, THRESH_W signed: weak threshold.
- alpha, in, ALPHA_W signed: weak vote weight.
- polarity, in, 1: comparison sense.
- ii_rd_en, out, 1: integral-image read strobe.
- ii_addr, out, 9: read address = y*20+x into the 20x20 zero-padded integral image.
- ii_rd_data, in, II_W: read data, valid exactly 1 cycle after ii_rd_en.

Function
REQ-003 FSM states: IDLE, LOAD, READ, DRAIN, VOTE, DONE.
REQ-004 Start handling:
- IDLE samples start=1 -> LOAD with rom_idx=0, score=0, err=0, busy=1.
- start in any other state is ignored.
REQ-005 LOAD (1 cycle): register all ROM outputs for rom_idx. rect_count>4 is treated as 4. Clear feature accumulator f.
REQ-006 READ (4n cycles, n = rect_count; skipped when n=0):
- Issues one read per cycle with ii_rd_en=1.
- Per rectangle k=0..n-1, corner order is D(y+h,x+w), B(y,x+w), C(y+h,x), A(y,x).
REQ-007 Accumulation: each returning word is applied to f as wt_k*(D-B-C+A), with signs +,-,-,+ per corner. Arithmetic is signed, 32 bits, no saturation.
REQ-008 Out-of-range rectangle: if x+w>19 or y+h>19, its four cycles still elapse with ii_rd_en=0, it contributes 0 to f, and err is set sticky.
REQ-009 DRAIN (1 cycle): absorbs the final read return.
REQ-010 VOTE (1 cycle):
- Pass is f<threshold when polarity=1, and f>=threshold when polarity=0.
- On pass, score += sign-extended alpha.
- If rom_idx<NUM_WEAK-1, increment rom_idx and go to LOAD; otherwise go to DONE.
REQ-011 Per-weak latency is exactly 4n+3 cycles.
REQ-012 DONE (1 cycle):
- done=1, face=(score>=stage_thresh), busy=0, then go to IDLE.
- done is asserted sum_i(4n_i+3)+1 cycles after the start-sampling edge.
REQ-013 Output holding: score, face and err hold until the next accepted start. rom_idx returns to 0 in IDLE.
REQ-014 Integral-image memory must stay unchanged while busy=1. The block performs no write access.
REQ-015 Score overflow is impossible for NUM_WEAK<=256 with SCORE_W=24, so there is no saturation logic.

Reset
REQ-016 rst_n=0 immediately forces IDLE and all outputs to 0: busy, done, face, score, err, rom_idx, ii_rd_en, ii_addr. No done pulse follows.
REQ-017 Release of rst_n requires no extra cycles. The first edge after release may accept start.

Verification
Bench ROM for all scenarios, NUM_WEAK=2:
- W0: rects (1,3,1,3,+1) and (1,6,1,3,-1); thr -61; alpha 208; pol 0.
- W1: rect (0,0,2,2,+1); thr 100; alpha 50; pol 1.
REQ-018 All-zero image, stage_thresh=258 -> score=258, face=1, done exactly 19 cycles after start. With stage_thresh=259 -> face=0.
REQ-019 Uniform pixel 255 image -> W0 f=0 (pass), W1 f=1020 (fail); score=208, err=0.
REQ-020 W1 read trace -> ii_addr sequence 42, 2, 40, 0 on consecutive cycles with ii_rd_en=1.
REQ-021 start pulsed during busy -> ignored, exactly one done. start one cycle after done -> accepted, identical result.
REQ-022 rst_n low during W0 READ -> all outputs 0 asynchronously, no done. Rerun after release gives the REQ-018 result.
REQ-023 W1 replaced by rect (18,0,2,1,+1) -> err=1, no reads for that rect, f=0 passes, score=258.
